// File: rtl/display_mux_6dig.sv
// display_mux_6dig
//   Time-multiplexed scan driver for a six-digit 7-segment clock display.
//   Each digit owns a DIV-cycle slot: the first BLANK cycles are dark
//   (anti-ghosting), then the digit is lit for the remaining DIV-BLANK cycles.
//   The digit's pattern is captured once per slot, so mid-slot input changes
//   never tear the displayed glyph.
//
// Ports
//   clock      in   system clock
//   reset      in   synchronous, active-high reset
//   s_lsd..h_msd in 7 each, segment patterns (gfedcba) from the digit decoders
//   seg        out  7  shared segment bus, registered
//   an         out  6  digit enables, active-low, at most one low at a time
//                      an[0]=s_lsd .. an[5]=h_msd
//   frame_tick out  1  one-cycle pulse when the scan wraps from digit 5 to 0
//
// Build option
//   DISPLAY_MUX_LZ_BLANK_EN : when defined, a leading zero on h_msd is shown
//   dark (an[5] still asserts for its normal window, so timing is unchanged).

module display_mux_6dig #(
  parameter int          DIV          = 50000,
  parameter int          BLANK        = 2500,
  parameter logic [6:0]  SEG_OFF      = 7'b1111111,
  parameter logic [6:0]  ZERO_PATTERN = 7'b1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] s_lsd,
  input  logic [6:0] s_msd,
  input  logic [6:0] m_lsd,
  input  logic [6:0] m_msd,
  input  logic [6:0] h_lsd,
  input  logic [6:0] h_msd,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       frame_tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_LITE = CW'(BLANK - 1);
  localparam logic [2:0]    IDX_LAST = 3'd5;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [6:0]    seg_q, seg_d;
  logic [5:0]    an_q,  an_d;
  logic          ft_q,  ft_d;
  logic [6:0]    sel_pat;
  logic          slot_end;

  assign slot_end = (cnt_q == CNT_LAST);

  // Pattern for the digit currently being scanned.
  always_comb begin
    sel_pat = SEG_OFF;
    case (idx_q)
      3'd0: sel_pat = s_lsd;
      3'd1: sel_pat = s_msd;
      3'd2: sel_pat = m_lsd;
      3'd3: sel_pat = m_msd;
      3'd4: sel_pat = h_lsd;
      3'd5: begin
`ifdef DISPLAY_MUX_LZ_BLANK_EN
        sel_pat = (h_msd == ZERO_PATTERN) ? SEG_OFF : h_msd;
`else
        sel_pat = h_msd;
`endif
      end
      default: sel_pat = SEG_OFF;
    endcase
  end

  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;

    // BLANK < DIV, so the light and dark edges never coincide.
    seg_d = seg_q;
    an_d  = an_q;
    if (cnt_q == CNT_LITE) begin
      seg_d = sel_pat;
      an_d  = ~(6'b000001 << idx_q);
    end else if (slot_end) begin
      seg_d = SEG_OFF;
      an_d  = 6'b111111;
    end

    ft_d = slot_end && (idx_q == IDX_LAST);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= 3'd0;
      seg_q <= SEG_OFF;
      an_q  <= 6'b111111;
      ft_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
      ft_q  <= ft_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_display_mux_6dig.sv
module tb_display_mux_6dig;

  localparam int DIV   = 8;
  localparam int BLANK = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] s_lsd, s_msd, m_lsd, m_msd, h_lsd, h_msd;
  logic [6:0] seg;
  logic [5:0] an;
  logic       frame_tick;

  int total = 0;
  int bad   = 0;

  logic [6:0] pat [6];

  display_mux_6dig #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clock(clock), .reset(reset),
    .s_lsd(s_lsd), .s_msd(s_msd), .m_lsd(m_lsd),
    .m_msd(m_msd), .h_lsd(h_lsd), .h_msd(h_msd),
    .seg(seg), .an(an), .frame_tick(frame_tick)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One reset edge, then release: cnt=0, idx=0, outputs dark.
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load_pats();
    pat[0] = 7'h40; pat[1] = 7'h79; pat[2] = 7'h24;
    pat[3] = 7'h30; pat[4] = 7'h19; pat[5] = 7'h12;
    s_lsd = pat[0]; s_msd = pat[1]; m_lsd = pat[2];
    m_msd = pat[3]; h_lsd = pat[4]; h_msd = pat[5];
  endtask

  task automatic test_reset();
    load_pats();
    reset = 1'b1;
    repeat (3) tick();
    total++; if (seg !== 7'h7F) begin bad++; $display("FAIL reset_seg got=%h exp=7f", seg); end
    total++; if (an !== 6'h3F) begin bad++; $display("FAIL reset_an got=%h exp=3f", an); end
    total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset_ft got=%b exp=0", frame_tick); end
    reset = 1'b0;
    tick();
    total++; if (an !== 6'h3F) begin bad++; $display("FAIL release_dark1 an got=%h exp=3f", an); end
    tick();
    total++; if (an !== 6'b111110) begin bad++; $display("FAIL release_lit an got=%b exp=111110", an); end
    total++; if (seg !== 7'h40) begin bad++; $display("FAIL release_lit seg got=%h exp=40", seg); end
  endtask

  // After k un-reset edges: cnt=k%8, slot=(k/8)%6; lit when cnt>=BLANK.
  task automatic test_scan();
    int c, s;
    logic [5:0] ean;
    logic [6:0] eseg;
    logic       eft;
    load_pats();
    do_reset();
    for (int k = 1; k <= 2 * 6 * DIV; k++) begin
      tick();
      c = k % DIV;
      s = (k / DIV) % 6;
      if (c >= BLANK) begin
        ean  = ~(6'b000001 << s);
        eseg = pat[s];
      end else begin
        ean  = 6'h3F;
        eseg = 7'h7F;
      end
      eft = (k % (6 * DIV)) == 0;
      total++; if (an !== ean) begin bad++; $display("FAIL scan_an k=%0d got=%b exp=%b", k, an, ean); end
      total++; if (seg !== eseg) begin bad++; $display("FAIL scan_seg k=%0d got=%h exp=%h", k, seg, eseg); end
      total++; if (frame_tick !== eft) begin bad++; $display("FAIL scan_ft k=%0d got=%b exp=%b", k, frame_tick, eft); end
    end
  endtask

  task automatic test_no_tear();
    load_pats();
    do_reset();
    repeat (4) tick();                       // k=4, idx0 mid-window
    s_lsd = 7'h79;
    for (int k = 4; k < DIV; k++) begin
      total++; if (seg !== 7'h40) begin bad++; $display("FAIL tear_hold k=%0d got=%h exp=40", k, seg); end
      tick();
    end
    total++; if (seg !== 7'h7F) begin bad++; $display("FAIL tear_dark got=%h exp=7f", seg); end
    repeat (6 * DIV + BLANK - DIV) tick();   // k=50: idx0 lit on next frame
    total++; if (an !== 6'b111110) begin bad++; $display("FAIL tear_next_an got=%b exp=111110", an); end
    total++; if (seg !== 7'h79) begin bad++; $display("FAIL tear_next_seg got=%h exp=79", seg); end
  endtask

  task automatic test_reset_mid();
    load_pats();
    do_reset();
    repeat (3 * DIV + 5) tick();             // idx=3, cnt=5
    total++; if (an !== 6'b110111) begin bad++; $display("FAIL mid_pre an got=%b exp=110111", an); end
    reset = 1'b1;
    tick();
    total++; if (an !== 6'h3F) begin bad++; $display("FAIL mid_rst an got=%h exp=3f", an); end
    total++; if (seg !== 7'h7F) begin bad++; $display("FAIL mid_rst seg got=%h exp=7f", seg); end
    reset = 1'b0;
    tick();
    total++; if (an !== 6'h3F) begin bad++; $display("FAIL mid_restart_dark an got=%h exp=3f", an); end
    tick();
    total++; if (an !== 6'b111110) begin bad++; $display("FAIL mid_restart an got=%b exp=111110", an); end
    total++; if (seg !== 7'h40) begin bad++; $display("FAIL mid_restart seg got=%h exp=40", seg); end
  endtask

  task automatic test_leading_zero();
    logic [6:0] exp0;
`ifdef DISPLAY_MUX_LZ_BLANK_EN
    exp0 = 7'h7F;
`else
    exp0 = 7'h40;
`endif
    load_pats();
    h_msd = 7'h40;
    do_reset();
    repeat (5 * DIV + 3) tick();             // idx5 active
    total++; if (an !== 6'b011111) begin bad++; $display("FAIL lz_an got=%b exp=011111", an); end
    total++; if (seg !== exp0) begin bad++; $display("FAIL lz_zero seg got=%h exp=%h", seg, exp0); end
    h_msd = 7'h79;
    repeat (6 * DIV) tick();
    total++; if (an !== 6'b011111) begin bad++; $display("FAIL lz_an2 got=%b exp=011111", an); end
    total++; if (seg !== 7'h79) begin bad++; $display("FAIL lz_nonzero seg got=%h exp=79", seg); end
    // Other digits are never suppressed: a zero on s_lsd still shows.
    s_lsd = 7'h40;
    repeat (DIV) tick();                     // back at idx0 active
    total++; if (seg !== 7'h40) begin bad++; $display("FAIL lz_other seg got=%h exp=40", seg); end
  endtask

  task automatic test_onehot();
    logic prev_ft;
    int   low;
    do_reset();
    prev_ft = 1'b0;
    for (int k = 0; k < 20 * 6 * DIV; k++) begin
      s_lsd = 7'($urandom); s_msd = 7'($urandom); m_lsd = 7'($urandom);
      m_msd = 7'($urandom); h_lsd = 7'($urandom); h_msd = 7'($urandom);
      tick();
      low = $countones(~an);
      total++; if (low > 1) begin bad++; $display("FAIL onehot k=%0d an=%b lows=%0d exp<=1", k, an, low); end
      total++; if (prev_ft && frame_tick) begin bad++; $display("FAIL ft_double k=%0d got=11 exp=not both", k); end
      prev_ft = frame_tick;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_no_tear();
    test_reset_mid();
    test_leading_zero();
    test_onehot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
